// File: rtl/ldu_iq_gen2.sv
// LDU issue queue: age-ordered compacting queue with writeback and optional fast-forward wakeup.
// Fast-forward wakeup is built only when LDU_IQ_FAST_FORWARD_EN is defined.
package core_types_pkg;
  localparam int LOG_PR_COUNT       = 7;
  localparam int PRF_BANK_COUNT     = 4;
  localparam int LOG_PRF_BANK_COUNT = 2;
  localparam int LOG_LDU_CQ_ENTRIES = 4;
endpackage

module ldu_iq_gen2
  import core_types_pkg::*;
#(
  parameter int LDU_IQ_ENTRIES              = 8,
  parameter int FAST_FORWARD_PIPE_COUNT     = 4,
  parameter int LOG_FAST_FORWARD_PIPE_COUNT = $clog2(FAST_FORWARD_PIPE_COUNT)
) (
  input  logic                                       CLK,
  input  logic                                       nRST,
  input  logic                                       ldu_iq_enq_valid,
  input  logic [3:0]                                 ldu_iq_enq_op,
  input  logic [11:0]                                ldu_iq_enq_imm12,
  input  logic [LOG_PR_COUNT-1:0]                    ldu_iq_enq_A_PR,
  input  logic                                       ldu_iq_enq_A_ready,
  input  logic                                       ldu_iq_enq_A_is_zero,
  input  logic [LOG_LDU_CQ_ENTRIES-1:0]              ldu_iq_enq_cq_index,
  output logic                                       ldu_iq_enq_ready,
  input  logic [PRF_BANK_COUNT-1:0]                  WB_bus_valid_by_bank,
  input  logic [PRF_BANK_COUNT-1:0][LOG_PR_COUNT-LOG_PRF_BANK_COUNT-1:0] WB_bus_upper_PR_by_bank,
  input  logic [FAST_FORWARD_PIPE_COUNT-1:0]         fast_forward_notif_valid_by_pipe,
  input  logic [FAST_FORWARD_PIPE_COUNT-1:0][LOG_PR_COUNT-1:0] fast_forward_notif_PR_by_pipe,
  output logic                                       issue_valid,
  output logic [3:0]                                 issue_op,
  output logic [11:0]                                issue_imm12,
  output logic                                       issue_A_is_reg,
  output logic                                       issue_A_is_bus_forward,
  output logic                                       issue_A_is_fast_forward,
  output logic [LOG_FAST_FORWARD_PIPE_COUNT-1:0]     issue_A_fast_forward_pipe,
  output logic [LOG_PRF_BANK_COUNT-1:0]              issue_A_bank,
  output logic [LOG_LDU_CQ_ENTRIES-1:0]              issue_cq_index,
  input  logic                                       issue_ready,
  output logic                                       PRF_req_A_valid,
  output logic [LOG_PR_COUNT-1:0]                    PRF_req_A_PR,
  input  logic                                       flush_valid
);

  localparam int N    = LDU_IQ_ENTRIES;
  localparam int IDXW = $clog2(LDU_IQ_ENTRIES);

  logic [N-1:0]                  valid_q;
  logic [3:0]                    op_q      [N];
  logic [11:0]                   imm_q     [N];
  logic [LOG_PR_COUNT-1:0]       pr_q      [N];
  logic                          ready_q   [N];
  logic                          zero_q    [N];
  logic [LOG_LDU_CQ_ENTRIES-1:0] cq_q      [N];

  logic [N-1:0]                  n_valid;
  logic [3:0]                    n_op      [N];
  logic [11:0]                   n_imm     [N];
  logic [LOG_PR_COUNT-1:0]       n_pr      [N];
  logic                          n_ready   [N];
  logic                          n_zero    [N];
  logic [LOG_LDU_CQ_ENTRIES-1:0] n_cq      [N];

  logic [N-1:0]                  wb_hit;
  logic [N-1:0]                  ff_hit;
  logic [LOG_FAST_FORWARD_PIPE_COUNT-1:0] ff_pipe [N];
  logic [N-1:0]                  entry_rdy;
  logic                          sel_found;
  logic [IDXW-1:0]               sel_idx;
  logic                          remove;
  logic                          enq_fire;
  logic [IDXW-1:0]               enq_slot;
  logic                          enq_wb_hit;

  function automatic logic wb_match(input logic [LOG_PR_COUNT-1:0] pr);
    logic [LOG_PRF_BANK_COUNT-1:0] b;
    b = pr[LOG_PRF_BANK_COUNT-1:0];
    return WB_bus_valid_by_bank[b] &&
           (WB_bus_upper_PR_by_bank[b] == pr[LOG_PR_COUNT-1:LOG_PRF_BANK_COUNT]);
  endfunction

  always_comb begin
    for (int i = 0; i < N; i++) begin
      wb_hit[i] = wb_match(pr_q[i]);
    end
    enq_wb_hit = wb_match(ldu_iq_enq_A_PR);
  end

`ifdef LDU_IQ_FAST_FORWARD_EN
  // Scan pipes from the top down so the lowest matching pipe wins.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      ff_hit[i]  = 1'b0;
      ff_pipe[i] = '0;
      for (int p = FAST_FORWARD_PIPE_COUNT-1; p >= 0; p--) begin
        if (fast_forward_notif_valid_by_pipe[p] &&
            fast_forward_notif_PR_by_pipe[p] == pr_q[i]) begin
          ff_hit[i]  = 1'b1;
          ff_pipe[i] = LOG_FAST_FORWARD_PIPE_COUNT'(p);
        end
      end
    end
  end
`else
  logic unused_ff;
  assign unused_ff = ^{fast_forward_notif_valid_by_pipe, fast_forward_notif_PR_by_pipe};

  always_comb begin
    ff_hit = '0;
    for (int i = 0; i < N; i++) begin
      ff_pipe[i] = '0;
    end
  end
`endif

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = N-1; i >= 0; i--) begin
      entry_rdy[i] = zero_q[i] | ready_q[i] | wb_hit[i] | ff_hit[i];
      if (valid_q[i] && entry_rdy[i]) begin
        sel_found = 1'b1;
        sel_idx   = IDXW'(i);
      end
    end
  end

  assign ldu_iq_enq_ready = ~valid_q[N-1];
  assign issue_valid      = sel_found & ~flush_valid;
  assign remove           = issue_valid & issue_ready;
  assign enq_fire         = ldu_iq_enq_valid & ldu_iq_enq_ready & ~flush_valid;

  assign issue_op        = op_q[sel_idx];
  assign issue_imm12     = imm_q[sel_idx];
  assign issue_cq_index  = cq_q[sel_idx];
  assign issue_A_bank    = pr_q[sel_idx][LOG_PRF_BANK_COUNT-1:0];
  assign PRF_req_A_PR    = pr_q[sel_idx];
  assign PRF_req_A_valid = issue_valid & issue_A_is_reg;

  // Operand source flags are exclusive: zero, then stored-ready, then bus, then fast-forward.
  always_comb begin
    issue_A_is_reg            = 1'b0;
    issue_A_is_bus_forward    = 1'b0;
    issue_A_is_fast_forward   = 1'b0;
    issue_A_fast_forward_pipe = '0;
    if (!zero_q[sel_idx]) begin
      if (ready_q[sel_idx]) begin
        issue_A_is_reg = 1'b1;
      end else if (wb_hit[sel_idx]) begin
        issue_A_is_bus_forward = 1'b1;
      end else begin
        issue_A_is_fast_forward   = ff_hit[sel_idx];
        issue_A_fast_forward_pipe = ff_pipe[sel_idx];
      end
    end
  end

  // Entries at or above the removed one shift down a slot; enqueue lands in the first free slot.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      n_valid[i] = valid_q[i];
      n_op[i]    = op_q[i];
      n_imm[i]   = imm_q[i];
      n_pr[i]    = pr_q[i];
      n_ready[i] = ready_q[i] | wb_hit[i];
      n_zero[i]  = zero_q[i];
      n_cq[i]    = cq_q[i];
    end
    if (remove) begin
      for (int i = 0; i < N-1; i++) begin
        if (i >= int'(sel_idx)) begin
          n_valid[i] = valid_q[i+1];
          n_op[i]    = op_q[i+1];
          n_imm[i]   = imm_q[i+1];
          n_pr[i]    = pr_q[i+1];
          n_ready[i] = ready_q[i+1] | wb_hit[i+1];
          n_zero[i]  = zero_q[i+1];
          n_cq[i]    = cq_q[i+1];
        end
      end
      n_valid[N-1] = 1'b0;
    end
    enq_slot = '0;
    for (int i = N-1; i >= 0; i--) begin
      if (!n_valid[i]) begin
        enq_slot = IDXW'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (enq_fire && IDXW'(i) == enq_slot) begin
        n_valid[i] = 1'b1;
        n_op[i]    = ldu_iq_enq_op;
        n_imm[i]   = ldu_iq_enq_imm12;
        n_pr[i]    = ldu_iq_enq_A_PR;
        n_ready[i] = ldu_iq_enq_A_ready | enq_wb_hit;
        n_zero[i]  = ldu_iq_enq_A_is_zero;
        n_cq[i]    = ldu_iq_enq_cq_index;
      end
    end
    if (flush_valid) begin
      n_valid = '0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_q <= '0;
    end else begin
      valid_q <= n_valid;
    end
  end

  always_ff @(posedge CLK) begin
    for (int i = 0; i < N; i++) begin
      op_q[i]    <= n_op[i];
      imm_q[i]   <= n_imm[i];
      pr_q[i]    <= n_pr[i];
      ready_q[i] <= n_ready[i];
      zero_q[i]  <= n_zero[i];
      cq_q[i]    <= n_cq[i];
    end
  end

endmodule

// File: tb/tb_ldu_iq_gen2.sv
// Directed bench for ldu_iq_gen2; fast-forward expectations follow LDU_IQ_FAST_FORWARD_EN.
module tb_ldu_iq_gen2;
  import core_types_pkg::*;

  logic CLK = 1'b0;
  logic nRST;
  logic ldu_iq_enq_valid;
  logic [3:0] ldu_iq_enq_op;
  logic [11:0] ldu_iq_enq_imm12;
  logic [6:0] ldu_iq_enq_A_PR;
  logic ldu_iq_enq_A_ready;
  logic ldu_iq_enq_A_is_zero;
  logic [3:0] ldu_iq_enq_cq_index;
  logic ldu_iq_enq_ready;
  logic [3:0] WB_bus_valid_by_bank;
  logic [3:0][4:0] WB_bus_upper_PR_by_bank;
  logic [3:0] fast_forward_notif_valid_by_pipe;
  logic [3:0][6:0] fast_forward_notif_PR_by_pipe;
  logic issue_valid;
  logic [3:0] issue_op;
  logic [11:0] issue_imm12;
  logic issue_A_is_reg;
  logic issue_A_is_bus_forward;
  logic issue_A_is_fast_forward;
  logic [1:0] issue_A_fast_forward_pipe;
  logic [1:0] issue_A_bank;
  logic [3:0] issue_cq_index;
  logic issue_ready;
  logic PRF_req_A_valid;
  logic [6:0] PRF_req_A_PR;
  logic flush_valid;

  int n_checks = 0;
  int n_fail = 0;

  ldu_iq_gen2 dut (
    .CLK(CLK), .nRST(nRST),
    .ldu_iq_enq_valid(ldu_iq_enq_valid), .ldu_iq_enq_op(ldu_iq_enq_op),
    .ldu_iq_enq_imm12(ldu_iq_enq_imm12), .ldu_iq_enq_A_PR(ldu_iq_enq_A_PR),
    .ldu_iq_enq_A_ready(ldu_iq_enq_A_ready), .ldu_iq_enq_A_is_zero(ldu_iq_enq_A_is_zero),
    .ldu_iq_enq_cq_index(ldu_iq_enq_cq_index), .ldu_iq_enq_ready(ldu_iq_enq_ready),
    .WB_bus_valid_by_bank(WB_bus_valid_by_bank), .WB_bus_upper_PR_by_bank(WB_bus_upper_PR_by_bank),
    .fast_forward_notif_valid_by_pipe(fast_forward_notif_valid_by_pipe),
    .fast_forward_notif_PR_by_pipe(fast_forward_notif_PR_by_pipe),
    .issue_valid(issue_valid), .issue_op(issue_op), .issue_imm12(issue_imm12),
    .issue_A_is_reg(issue_A_is_reg), .issue_A_is_bus_forward(issue_A_is_bus_forward),
    .issue_A_is_fast_forward(issue_A_is_fast_forward),
    .issue_A_fast_forward_pipe(issue_A_fast_forward_pipe), .issue_A_bank(issue_A_bank),
    .issue_cq_index(issue_cq_index), .issue_ready(issue_ready),
    .PRF_req_A_valid(PRF_req_A_valid), .PRF_req_A_PR(PRF_req_A_PR), .flush_valid(flush_valid)
  );

  always #5 CLK = ~CLK;

  // Inputs change 1 time unit after the rising edge; outputs are checked 1 unit after that.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_idle();
    ldu_iq_enq_valid = 0; ldu_iq_enq_op = 0; ldu_iq_enq_imm12 = 0; ldu_iq_enq_A_PR = 0;
    ldu_iq_enq_A_ready = 0; ldu_iq_enq_A_is_zero = 0; ldu_iq_enq_cq_index = 0;
    WB_bus_valid_by_bank = 0; WB_bus_upper_PR_by_bank = '0;
    fast_forward_notif_valid_by_pipe = 0; fast_forward_notif_PR_by_pipe = '0;
    issue_ready = 0; flush_valid = 0;
  endtask

  task automatic enq(input logic [6:0] pr, input logic rdy, input logic zero, input logic [3:0] cq);
    ldu_iq_enq_valid = 1; ldu_iq_enq_A_PR = pr; ldu_iq_enq_A_ready = rdy;
    ldu_iq_enq_A_is_zero = zero; ldu_iq_enq_cq_index = cq;
    ldu_iq_enq_op = cq; ldu_iq_enq_imm12 = {8'h00, cq};
    tick();
    ldu_iq_enq_valid = 0;
  endtask

  task automatic do_flush();
    flush_valid = 1;
    tick();
    flush_valid = 0;
  endtask

  task automatic test_reset();
    set_idle();
    nRST = 0;
    #12;
    n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL reset_issue_valid: got %0b expected 0", issue_valid); end
    n_checks++; if (PRF_req_A_valid !== 1'b0) begin n_fail++; $display("FAIL reset_prf_valid: got %0b expected 0", PRF_req_A_valid); end
    n_checks++; if (ldu_iq_enq_ready !== 1'b1) begin n_fail++; $display("FAIL reset_enq_ready: got %0b expected 1", ldu_iq_enq_ready); end
    @(negedge CLK);
    nRST = 1;
    tick();
  endtask

  task automatic test_basic_issue();
    ldu_iq_enq_op = 4'h2; ldu_iq_enq_imm12 = 12'h123;
    ldu_iq_enq_valid = 1; ldu_iq_enq_A_PR = 7'd5; ldu_iq_enq_A_ready = 1;
    ldu_iq_enq_A_is_zero = 0; ldu_iq_enq_cq_index = 4'd3;
    #1;
    n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL basic_no_bypass: got %0b expected 0", issue_valid); end
    tick();
    ldu_iq_enq_valid = 0; issue_ready = 1;
    #1;
    n_checks++; if (issue_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %0b expected 1", issue_valid); end
    n_checks++; if (issue_A_is_reg !== 1'b1) begin n_fail++; $display("FAIL basic_is_reg: got %0b expected 1", issue_A_is_reg); end
    n_checks++; if (issue_A_bank !== 2'd1) begin n_fail++; $display("FAIL basic_bank: got %0d expected 1", issue_A_bank); end
    n_checks++; if (PRF_req_A_valid !== 1'b1) begin n_fail++; $display("FAIL basic_prf_valid: got %0b expected 1", PRF_req_A_valid); end
    n_checks++; if (PRF_req_A_PR !== 7'd5) begin n_fail++; $display("FAIL basic_prf_pr: got %0d expected 5", PRF_req_A_PR); end
    n_checks++; if ({issue_op, issue_imm12, issue_cq_index} !== {4'h2, 12'h123, 4'd3}) begin n_fail++; $display("FAIL basic_payload: got %h/%h/%h expected 2/123/3", issue_op, issue_imm12, issue_cq_index); end
    tick();
    issue_ready = 0;
    n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL basic_removed: got %0b expected 0", issue_valid); end
  endtask

  task automatic test_wb_wakeup();
    enq(7'd6, 1'b0, 1'b0, 4'd4);
    n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL wb_not_ready: got %0b expected 0", issue_valid); end
    WB_bus_valid_by_bank = 4'b0100; WB_bus_upper_PR_by_bank[2] = 5'd2;
    #1;
    n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL wb_wrong_upper: got %0b expected 0", issue_valid); end
    WB_bus_upper_PR_by_bank[2] = 5'd1;
    #1;
    n_checks++; if (issue_valid !== 1'b1) begin n_fail++; $display("FAIL wb_hit_valid: got %0b expected 1", issue_valid); end
    n_checks++; if ({issue_A_is_reg, issue_A_is_bus_forward, issue_A_is_fast_forward} !== 3'b010) begin n_fail++; $display("FAIL wb_hit_flags: got %b expected 010", {issue_A_is_reg, issue_A_is_bus_forward, issue_A_is_fast_forward}); end
    n_checks++; if (issue_A_bank !== 2'd2) begin n_fail++; $display("FAIL wb_hit_bank: got %0d expected 2", issue_A_bank); end
    n_checks++; if (PRF_req_A_valid !== 1'b0) begin n_fail++; $display("FAIL wb_hit_prf: got %0b expected 0", PRF_req_A_valid); end
    tick();
    WB_bus_valid_by_bank = 0;
    #1;
    n_checks++; if (issue_valid !== 1'b1) begin n_fail++; $display("FAIL wb_stored_valid: got %0b expected 1", issue_valid); end
    n_checks++; if ({issue_A_is_reg, issue_A_is_bus_forward, issue_A_is_fast_forward} !== 3'b100) begin n_fail++; $display("FAIL wb_stored_flags: got %b expected 100", {issue_A_is_reg, issue_A_is_bus_forward, issue_A_is_fast_forward}); end
    n_checks++; if ({PRF_req_A_valid, PRF_req_A_PR} !== {1'b1, 7'd6}) begin n_fail++; $display("FAIL wb_stored_prf: got %0b/%0d expected 1/6", PRF_req_A_valid, PRF_req_A_PR); end
    issue_ready = 1;
    tick();
    issue_ready = 0;
    n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL wb_drained: got %0b expected 0", issue_valid); end
    // A writeback arriving during enqueue must be captured with the new entry.
    WB_bus_valid_by_bank = 4'b0100; WB_bus_upper_PR_by_bank[2] = 5'd1;
    enq(7'd6, 1'b0, 1'b0, 4'd5);
    WB_bus_valid_by_bank = 0;
    #1;
    n_checks++; if ({issue_valid, issue_A_is_reg, issue_cq_index} !== {1'b1, 1'b1, 4'd5}) begin n_fail++; $display("FAIL wb_enq_capture: got %0b/%0b/%0d expected 1/1/5", issue_valid, issue_A_is_reg, issue_cq_index); end
    do_flush();
  endtask

  task automatic test_fast_forward();
    enq(7'd9, 1'b0, 1'b0, 4'd6);
    fast_forward_notif_valid_by_pipe = 4'b1010;
    fast_forward_notif_PR_by_pipe[0] = 7'd9;
    fast_forward_notif_PR_by_pipe[1] = 7'd9;
    fast_forward_notif_PR_by_pipe[3] = 7'd9;
    #1;
`ifdef LDU_IQ_FAST_FORWARD_EN
    n_checks++; if (issue_valid !== 1'b1) begin n_fail++; $display("FAIL ff_valid: got %0b expected 1", issue_valid); end
    n_checks++; if ({issue_A_is_reg, issue_A_is_bus_forward, issue_A_is_fast_forward} !== 3'b001) begin n_fail++; $display("FAIL ff_flags: got %b expected 001", {issue_A_is_reg, issue_A_is_bus_forward, issue_A_is_fast_forward}); end
    n_checks++; if (issue_A_fast_forward_pipe !== 2'd1) begin n_fail++; $display("FAIL ff_pipe: got %0d expected 1", issue_A_fast_forward_pipe); end
    n_checks++; if (PRF_req_A_valid !== 1'b0) begin n_fail++; $display("FAIL ff_prf: got %0b expected 0", PRF_req_A_valid); end
`else
    n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL ff_disabled: got %0b expected 0", issue_valid); end
`endif
    tick();
    fast_forward_notif_valid_by_pipe = 0;
    #1;
    n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL ff_not_sticky: got %0b expected 0", issue_valid); end
    do_flush();
  endtask

  task automatic test_fill_and_order();
    for (int i = 0; i < 8; i++) begin
      n_checks++; if (ldu_iq_enq_ready !== 1'b1) begin n_fail++; $display("FAIL fill_enq_ready_%0d: got %0b expected 1", i, ldu_iq_enq_ready); end
      enq(7'(16 + i), 1'b1, 1'b0, 4'(i));
    end
    n_checks++; if (ldu_iq_enq_ready !== 1'b0) begin n_fail++; $display("FAIL fill_full: got %0b expected 0", ldu_iq_enq_ready); end
    // Enqueue while full and issuing: the enqueue must still be refused.
    issue_ready = 1;
    enq(7'd40, 1'b1, 1'b0, 4'd15);
    issue_ready = 0;
    n_checks++; if (ldu_iq_enq_ready !== 1'b1) begin n_fail++; $display("FAIL fill_reopen: got %0b expected 1", ldu_iq_enq_ready); end
    issue_ready = 1;
    for (int i = 1; i < 8; i++) begin
      n_checks++; if ({issue_valid, issue_cq_index, PRF_req_A_PR} !== {1'b1, 4'(i), 7'(16 + i)}) begin n_fail++; $display("FAIL order_%0d: got %0b/%0d/%0d expected 1/%0d/%0d", i, issue_valid, issue_cq_index, PRF_req_A_PR, i, 16 + i); end
      tick();
    end
    n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL order_empty: got %0b expected 0", issue_valid); end
    issue_ready = 0;
  endtask

  task automatic test_out_of_order_and_zero();
    enq(7'd10, 1'b0, 1'b0, 4'd0);
    enq(7'd11, 1'b1, 1'b0, 4'd1);
    enq(7'd12, 1'b0, 1'b1, 4'd2);
    issue_ready = 1;
    #1;
    n_checks++; if ({issue_valid, issue_cq_index, issue_A_is_reg} !== {1'b1, 4'd1, 1'b1}) begin n_fail++; $display("FAIL ooo_first: got %0b/%0d/%0b expected 1/1/1", issue_valid, issue_cq_index, issue_A_is_reg); end
    tick();
    n_checks++; if ({issue_valid, issue_cq_index} !== {1'b1, 4'd2}) begin n_fail++; $display("FAIL zero_select: got %0b/%0d expected 1/2", issue_valid, issue_cq_index); end
    n_checks++; if ({issue_A_is_reg, issue_A_is_bus_forward, issue_A_is_fast_forward, PRF_req_A_valid} !== 4'b0000) begin n_fail++; $display("FAIL zero_flags: got %b expected 0000", {issue_A_is_reg, issue_A_is_bus_forward, issue_A_is_fast_forward, PRF_req_A_valid}); end
    tick();
    n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL ooo_oldest_waits: got %0b expected 0", issue_valid); end
    issue_ready = 0;
    do_flush();
  endtask

  task automatic test_flush_and_reset();
    for (int i = 0; i < 4; i++) enq(7'(20 + i), 1'b1, 1'b0, 4'(8 + i));
    flush_valid = 1; issue_ready = 1;
    ldu_iq_enq_valid = 1; ldu_iq_enq_A_PR = 7'd30; ldu_iq_enq_A_ready = 1; ldu_iq_enq_cq_index = 4'd14;
    #1;
    n_checks++; if ({issue_valid, PRF_req_A_valid} !== 2'b00) begin n_fail++; $display("FAIL flush_suppress: got %b expected 00", {issue_valid, PRF_req_A_valid}); end
    n_checks++; if (ldu_iq_enq_ready !== 1'b1) begin n_fail++; $display("FAIL flush_enq_ready: got %0b expected 1", ldu_iq_enq_ready); end
    tick();
    flush_valid = 0; ldu_iq_enq_valid = 0;
    #1;
    n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL flush_empty: got %0b expected 0", issue_valid); end
    issue_ready = 0;
    for (int i = 0; i < 3; i++) enq(7'(20 + i), 1'b1, 1'b0, 4'(i));
    #2;
    nRST = 0;
    #1;
    n_checks++; if ({issue_valid, ldu_iq_enq_ready} !== 2'b01) begin n_fail++; $display("FAIL midreset_state: got %b expected 01", {issue_valid, ldu_iq_enq_ready}); end
    @(negedge CLK);
    nRST = 1;
    tick();
    n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_empty: got %0b expected 0", issue_valid); end
  endtask

  initial begin
    test_reset();
    test_basic_issue();
    test_wb_wakeup();
    test_fast_forward();
    test_fill_and_order();
    test_out_of_order_and_zero();
    test_flush_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
